sigmoid_sweep_checker: RTL and testbench
========================================

SIGMOID_SWEEP_CHECKER -- requirements
Module: sigmoid_sweep_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, cycles sig_in is held stable before each sig_out sample (legal 1..15).
REQ-002 SHALL have parameter ONE_VAL, default 16'h0800, the value 1.0 in the signed Q5.11 output format (0x0000 = 0.0).
REQ-003 Ports, clock and reset first (name direction width meaning):
- clk  input  1  single clock; all state changes on the rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  one-cycle request to begin a sweep
- start_val  input  16  first input point, signed Q5.11
- stop_val  input  16  last allowed input point, signed Q5.11
- step  input  16  unsigned increment between points
- sig_in  output  16  drives the sigmoid unit's in port
- sig_out  input  16  sigmoid unit's out port, signed Q5.11
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse at sweep end
- pass  output  1  1 when the last sweep had zero errors
- mono_err  output  1  sticky: a monotonicity violation occurred
- range_err  output  1  sticky: a range violation occurred
- err_count  output  8  samples with at least one violation, saturating
- sample_count  output  16  samples taken in the current/last sweep

Function
REQ-004 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-005 IDLE: on start=1, SHALL load sig_in=start_val, clear mono_err, range_err, err_count, sample_count and pass, set busy=1, load settle counter to SETTLE_CYCLES, enter SETTLE.
REQ-006 start SHALL be ignored in SETTLE, SAMPLE and DONE.
REQ-007 SETTLE SHALL last exactly SETTLE_CYCLES cycles with sig_in constant, then enter SAMPLE.
REQ-008 SAMPLE SHALL last one cycle; sig_out is captured on that edge and sample_count increments by 1.
REQ-009 Range violation: sig_out < 0 or sig_out > ONE_VAL (signed compare); sets range_err.
REQ-010 Monotonicity violation: on every sample except the first of a sweep, sig_out < previous captured sig_out (signed); sets mono_err.
REQ-011 err_count SHALL increment by exactly 1 per sample having any violation and saturate at 255.
REQ-012 Next point SHALL be computed as 17-bit signed sum sig_in + zero-extended step; step=0 SHALL be treated as step=1.
REQ-013 After SAMPLE: if next > stop_val or next > 16'sh7FFF (no wrap to negative), enter DONE; otherwise sig_in=next, reload settle counter, enter SETTLE.
REQ-014 If start_val > stop_val, exactly one sample at start_val SHALL be taken, then DONE.
REQ-015 DONE SHALL last one cycle: done=1, busy=0, pass=(err_count==0 including the final sample); then IDLE.
REQ-016 Per-point cost SHALL be SETTLE_CYCLES+1 cycles; done SHALL assert N*(SETTLE_CYCLES+1)+1 cycles after the start-accept edge for N points.
REQ-017 sig_in, flags, counts and pass SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-018 When rst_n=0 at a rising edge, regardless of state (including mid-sweep), SHALL enter IDLE with sig_in=0, busy=0, done=0, pass=0, mono_err=0, range_err=0, err_count=0, sample_count=0, previous-sample register=0.
REQ-019 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Verification
REQ-020 Ideal sigmoid model, start_val=16'hE000 (-4), stop_val=16'h2000 (+4), step=16'h0400 (0.5) -> 17 samples, done 52 cycles after accept, pass=1, err_count=0.
REQ-021 Model output forced to decrease by 1 LSB at input 0 -> mono_err=1, range_err=0, err_count=1, pass=0.
REQ-022 Model returns 16'h0900 for two points and 16'hFFFF for one -> range_err=1, err_count=3, pass=0.
REQ-023 start_val=16'h7FF0, stop_val=16'h7FFF, step=16'h0010 -> one sample at 16'h7FF0, no wrap, done; step=0 with start_val=stop_val-2 -> 3 samples.
REQ-024 rst_n=0 during SETTLE of point 5 -> next cycle IDLE, all outputs at reset values; new start then runs a clean 17-sample sweep with pass=1.
REQ-025 start pulsed while busy -> ignored; sample_count and done timing unchanged from REQ-020.

Source files
------------

// File: rtl/sigmoid_sweep_checker.sv
// Sweeps a sigmoid unit's input across a range and checks every sampled output
// for range (0..1.0) and monotonicity violations, reporting a pass/fail summary.
module sigmoid_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] ONE_VAL       = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] start_val,
    input  logic [15:0] stop_val,
    input  logic [15:0] step,
    output logic [15:0] sig_in,
    input  logic [15:0] sig_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        mono_err,
    output logic        range_err,
    output logic [7:0]  err_count,
    output logic [15:0] sample_count
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t             state;
    state_t             state_next;
    logic [3:0]         settle_cnt;
    logic [15:0]        stop_q;
    logic [15:0]        step_q;
    logic [15:0]        prev_q;
    logic               first_q;
    logic [15:0]        step_eff;
    logic signed [16:0] next_point;
    logic               sweep_end;
    logic               range_hit;
    logic               mono_hit;

    // Next point is formed one bit wider so a step past +max is seen as an end, not a wrap.
    always_comb begin
        step_eff   = (step_q == 16'd0) ? 16'd1 : step_q;
        next_point = $signed({sig_in[15], sig_in}) + $signed({1'b0, step_eff});
        sweep_end  = (next_point > $signed({stop_q[15], stop_q})) ||
                     (next_point > 17'sh07FFF);
        range_hit  = sig_out[15] || ($signed(sig_out) > $signed(ONE_VAL));
        mono_hit   = !first_q && ($signed(sig_out) < $signed(prev_q));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  if (settle_cnt <= 4'd1) state_next = SAMPLE;
            SAMPLE:  state_next = sweep_end ? DONE : SETTLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Results are registered, so done/pass appear on the edge that leaves DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_in       <= 16'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mono_err     <= 1'b0;
            range_err    <= 1'b0;
            err_count    <= 8'd0;
            sample_count <= 16'd0;
            settle_cnt   <= 4'd0;
            stop_q       <= 16'd0;
            step_q       <= 16'd0;
            prev_q       <= 16'd0;
            first_q      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sig_in       <= start_val;
                        stop_q       <= stop_val;
                        step_q       <= step;
                        mono_err     <= 1'b0;
                        range_err    <= 1'b0;
                        err_count    <= 8'd0;
                        sample_count <= 16'd0;
                        pass         <= 1'b0;
                        busy         <= 1'b1;
                        settle_cnt   <= SETTLE_LOAD;
                        first_q      <= 1'b1;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                end
                SAMPLE: begin
                    prev_q       <= sig_out;
                    first_q      <= 1'b0;
                    sample_count <= sample_count + 16'd1;
                    if (range_hit) range_err <= 1'b1;
                    if (mono_hit) mono_err <= 1'b1;
                    if ((range_hit || mono_hit) && (err_count != 8'hFF)) begin
                        err_count <= err_count + 8'd1;
                    end
                    if (!sweep_end) begin
                        sig_in     <= next_point[15:0];
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= (err_count == 8'd0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sigmoid_sweep_checker.sv
// Directed bench for sigmoid_sweep_checker driven by a clamped-linear sigmoid
// model with selectable fault injection.
module tb_sigmoid_sweep_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] start_val;
    logic [15:0] stop_val;
    logic [15:0] step;
    logic [15:0] sig_in;
    logic [15:0] sig_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic        mono_err;
    logic        range_err;
    logic [7:0]  err_count;
    logic [15:0] sample_count;

    int vectors;
    int miscompares;
    int mode;
    int lat;

    sigmoid_sweep_checker #(.SETTLE_CYCLES(2), .ONE_VAL(16'h0800)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .start_val(start_val),
        .stop_val(stop_val),
        .step(step),
        .sig_in(sig_in),
        .sig_out(sig_out),
        .busy(busy),
        .done(done),
        .pass(pass),
        .mono_err(mono_err),
        .range_err(range_err),
        .err_count(err_count),
        .sample_count(sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard sigmoid: 0.5 + x/8 clamped to [0, 1.0]; mode 1 dips at x=0, mode 2 leaves range.
    function automatic logic [15:0] model(input logic [15:0] x, input int m);
        int xi;
        int v;
        xi = int'($signed(x));
        v  = 1024 + (xi >>> 3);
        if (v < 0) v = 0;
        if (v > 2048) v = 2048;
        if (m == 1 && x == 16'h0000) v = 32'h037F;
        if (m == 2 && (x == 16'h1C00 || x == 16'h2000)) v = 32'h0900;
        if (m == 2 && x == 16'hE000) v = 32'hFFFF;
        return v[15:0];
    endfunction

    always_comb sig_out = model(sig_in, mode);

    task automatic run_sweep(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                             input int pa, input int pb, output int l);
        @(negedge clk);
        start_val = a;
        stop_val  = b;
        step      = c;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        l = -1;
        for (int k = 1; k <= 400; k++) begin
            start = (k == pa) || (k == pb);
            @(posedge clk);
            #1;
            if (done) begin
                l = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        start_val = 16'h1234;
        stop_val = 16'h2000;
        step = 16'h0100;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (sig_in !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_sig_in got %h want 0000", sig_in); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
        vectors++; if (pass !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pass got %b want 0", pass); end
        vectors++; if ({mono_err, range_err} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_flags got %b want 00", {mono_err, range_err}); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_err_count got %0d want 0", err_count); end
        vectors++; if (sample_count !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_sample_count got %0d want 0", sample_count); end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL start_in_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_ideal();
        mode = 0;
        run_sweep(16'hE000, 16'h2000, 16'h0400, 0, 0, lat);
        vectors++; if (lat !== 52) begin miscompares++; $display("[TB] FAIL ideal_latency got %0d want 52", lat); end
        vectors++; if (sample_count !== 16'd17) begin miscompares++; $display("[TB] FAIL ideal_samples got %0d want 17", sample_count); end
        vectors++; if (pass !== 1'b1) begin miscompares++; $display("[TB] FAIL ideal_pass got %b want 1", pass); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("[TB] FAIL ideal_err_count got %0d want 0", err_count); end
        vectors++; if ({mono_err, range_err} !== 2'b00) begin miscompares++; $display("[TB] FAIL ideal_flags got %b want 00", {mono_err, range_err}); end
        vectors++; if (sig_in !== 16'h2000) begin miscompares++; $display("[TB] FAIL ideal_last_point got %h want 2000", sig_in); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL ideal_busy_at_done got %b want 0", busy); end
    endtask

    task automatic test_hold();
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_done got %b want 0", done); end
        vectors++; if (sig_in !== 16'h2000) begin miscompares++; $display("[TB] FAIL hold_sig_in got %h want 2000", sig_in); end
        vectors++; if (sample_count !== 16'd17) begin miscompares++; $display("[TB] FAIL hold_samples got %0d want 17", sample_count); end
        vectors++; if (pass !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_pass got %b want 1", pass); end
    endtask

    task automatic test_mono();
        mode = 1;
        run_sweep(16'hE000, 16'h2000, 16'h0400, 0, 0, lat);
        vectors++; if (lat !== 52) begin miscompares++; $display("[TB] FAIL mono_latency got %0d want 52", lat); end
        vectors++; if (mono_err !== 1'b1) begin miscompares++; $display("[TB] FAIL mono_flag got %b want 1", mono_err); end
        vectors++; if (range_err !== 1'b0) begin miscompares++; $display("[TB] FAIL mono_range_flag got %b want 0", range_err); end
        vectors++; if (err_count !== 8'd1) begin miscompares++; $display("[TB] FAIL mono_err_count got %0d want 1", err_count); end
        vectors++; if (pass !== 1'b0) begin miscompares++; $display("[TB] FAIL mono_pass got %b want 0", pass); end
    endtask

    task automatic test_range();
        mode = 2;
        run_sweep(16'hE000, 16'h2000, 16'h0400, 0, 0, lat);
        vectors++; if (range_err !== 1'b1) begin miscompares++; $display("[TB] FAIL range_flag got %b want 1", range_err); end
        vectors++; if (mono_err !== 1'b0) begin miscompares++; $display("[TB] FAIL range_mono_flag got %b want 0", mono_err); end
        vectors++; if (err_count !== 8'd3) begin miscompares++; $display("[TB] FAIL range_err_count got %0d want 3", err_count); end
        vectors++; if (pass !== 1'b0) begin miscompares++; $display("[TB] FAIL range_pass got %b want 0", pass); end
        vectors++; if (sample_count !== 16'd17) begin miscompares++; $display("[TB] FAIL range_samples got %0d want 17", sample_count); end
    endtask

    task automatic test_no_wrap();
        mode = 0;
        run_sweep(16'h7FF0, 16'h7FFF, 16'h0010, 0, 0, lat);
        vectors++; if (lat !== 4) begin miscompares++; $display("[TB] FAIL nowrap_latency got %0d want 4", lat); end
        vectors++; if (sample_count !== 16'd1) begin miscompares++; $display("[TB] FAIL nowrap_samples got %0d want 1", sample_count); end
        vectors++; if (sig_in !== 16'h7FF0) begin miscompares++; $display("[TB] FAIL nowrap_sig_in got %h want 7ff0", sig_in); end
        vectors++; if (pass !== 1'b1) begin miscompares++; $display("[TB] FAIL nowrap_pass got %b want 1", pass); end
    endtask

    task automatic test_step_zero();
        mode = 0;
        run_sweep(16'h00FE, 16'h0100, 16'h0000, 0, 0, lat);
        vectors++; if (lat !== 10) begin miscompares++; $display("[TB] FAIL step0_latency got %0d want 10", lat); end
        vectors++; if (sample_count !== 16'd3) begin miscompares++; $display("[TB] FAIL step0_samples got %0d want 3", sample_count); end
        vectors++; if (sig_in !== 16'h0100) begin miscompares++; $display("[TB] FAIL step0_sig_in got %h want 0100", sig_in); end
    endtask

    task automatic test_reversed();
        mode = 0;
        run_sweep(16'h1000, 16'h0800, 16'h0400, 0, 0, lat);
        vectors++; if (lat !== 4) begin miscompares++; $display("[TB] FAIL reversed_latency got %0d want 4", lat); end
        vectors++; if (sample_count !== 16'd1) begin miscompares++; $display("[TB] FAIL reversed_samples got %0d want 1", sample_count); end
        vectors++; if (sig_in !== 16'h1000) begin miscompares++; $display("[TB] FAIL reversed_sig_in got %h want 1000", sig_in); end
    endtask

    task automatic test_mid_reset();
        mode = 0;
        @(negedge clk);
        start_val = 16'hE000;
        stop_val  = 16'h2000;
        step      = 16'h0400;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_busy_before got %b want 1", busy); end
        vectors++; if (sample_count !== 16'd4) begin miscompares++; $display("[TB] FAIL midrst_samples_before got %0d want 4", sample_count); end
        vectors++; if (sig_in !== 16'hF000) begin miscompares++; $display("[TB] FAIL midrst_point5 got %h want f000", sig_in); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vectors++; if (sig_in !== 16'h0000) begin miscompares++; $display("[TB] FAIL midrst_sig_in got %h want 0000", sig_in); end
        vectors++; if ({busy, done, pass} !== 3'b000) begin miscompares++; $display("[TB] FAIL midrst_status got %b want 000", {busy, done, pass}); end
        vectors++; if (sample_count !== 16'd0) begin miscompares++; $display("[TB] FAIL midrst_samples got %0d want 0", sample_count); end
        run_sweep(16'hE000, 16'h2000, 16'h0400, 0, 0, lat);
        vectors++; if (lat !== 52) begin miscompares++; $display("[TB] FAIL midrst_rerun_latency got %0d want 52", lat); end
        vectors++; if (sample_count !== 16'd17) begin miscompares++; $display("[TB] FAIL midrst_rerun_samples got %0d want 17", sample_count); end
        vectors++; if (pass !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_rerun_pass got %b want 1", pass); end
    endtask

    task automatic test_back_to_back();
        mode = 0;
        run_sweep(16'hE000, 16'h2000, 16'h0400, 10, 52, lat);
        vectors++; if (lat !== 52) begin miscompares++; $display("[TB] FAIL busystart_latency got %0d want 52", lat); end
        vectors++; if (sample_count !== 16'd17) begin miscompares++; $display("[TB] FAIL busystart_samples got %0d want 17", sample_count); end
        vectors++; if (pass !== 1'b1) begin miscompares++; $display("[TB] FAIL busystart_pass got %b want 1", pass); end
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL busystart_idle_after got %b want 0", busy); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        mode = 0;
        lat = 0;
        rst_n = 1'b0;
        start = 1'b0;
        start_val = 16'h0000;
        stop_val = 16'h0000;
        step = 16'h0000;
        test_reset();
        test_ideal();
        test_hold();
        test_mono();
        test_range();
        test_no_wrap();
        test_step_zero();
        test_reversed();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
